pipe_hazard_ctrl: RTL and testbench

//  Hazard/stall scheduler for the 5-stage pipeline (IF/ID/EX/MEM/WB).
//  - Sequences the PC and the IF_ID, ID_EX and EX_MEM registers: stall, flush and forwarding.
//  - Detects load-use and taken-branch hazards.
//  - Inserts RAM wait states for multi-cycle data-memory access.

---
 rtl/pipe_hazard_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
//   Hazard/stall scheduler for a 5-stage IF/ID/EX/MEM/WB pipeline.
//   - Operand forwarding selects (EX_MEM has priority over MEM_WB, x0 never
//     forwarded).
//   - Load-use detection: one-cycle PC/IF_ID hold plus an ID_EX bubble.
//   - Taken-branch flush of IF_ID and ID_EX.
//   - RAM wait-state FSM (RUN/WAIT): a data-RAM access freezes PC..EX_MEM and
//     bubbles MEM_WB for RAM_LAT-1 cycles.
//
// Parameters
//   RAM_LAT   data-RAM access latency in cycles (>=1)
//   LOAD_SEL  rf_wsel code for write-back from RAM (a load)
//
// Ports
//   clk, rst_n                     clock (rising edge), async active-low reset
//   id_rR1/id_rR2, id_re1/id_re2   ID-stage sources and their read enables
//   ex_wR, ex_rf_we, ex_rf_wsel    ID_EX destination / write enable / wb select
//   ex_br_taken                    branch/jump resolved taken in EX
//   mem_wR, mem_rf_we, mem_ram_acc EX_MEM destination / write enable / RAM access
//   wb_wR, wb_rf_we                MEM_WB destination / write enable
//   fwd_a_sel, fwd_b_sel           0 regfile, 1 EX_MEM.wD, 2 MEM_WB.wD
//   stall_*                        hold PC / IF_ID / ID_EX / EX_MEM
//   flush_*                        load bubble into IF_ID / ID_EX / MEM_WB
//   busy                           FSM holding a WAIT-state stall
//
// Optional feature (macro HAZARD_PERF_EN)
//   stall_cnt[31:0]  cycles with stall_pc=1    (wraps, reset to 0)
//   flush_cnt[31:0]  cycles with flush_id_ex=1 (wraps, reset to 0)
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
   parameter int unsigned RAM_LAT  = 3,
   parameter logic [1:0]  LOAD_SEL = 2'd1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [4:0] id_rR1,
   input  logic [4:0] id_rR2,
   input  logic       id_re1,
   input  logic       id_re2,
   input  logic [4:0] ex_wR,
   input  logic       ex_rf_we,
   input  logic [1:0] ex_rf_wsel,
   input  logic       ex_br_taken,
   input  logic [4:0] mem_wR,
   input  logic       mem_rf_we,
   input  logic       mem_ram_acc,
   input  logic [4:0] wb_wR,
   input  logic       wb_rf_we,
   output logic [1:0] fwd_a_sel,
   output logic [1:0] fwd_b_sel,
   output logic       stall_pc,
   output logic       stall_if_id,
   output logic       stall_id_ex,
   output logic       stall_ex_mem,
   output logic       flush_if_id,
   output logic       flush_id_ex,
   output logic       flush_mem_wb,
   output logic       busy
`ifdef HAZARD_PERF_EN
   ,
   output logic [31:0] stall_cnt,
   output logic [31:0] flush_cnt
`endif
);

   localparam int unsigned CNT_W    = (RAM_LAT > 2) ? ($clog2(RAM_LAT) + 1) : 2;
   localparam int unsigned CNT_INIT = (RAM_LAT > 1) ? (RAM_LAT - 2) : 0;
   localparam bit          MULTI    = (RAM_LAT > 1);

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_WAIT = 1'b1
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q,   cnt_d;
   logic               busy_q,  busy_d;
   logic               lu_block_q, lu_block_d;
   logic               memstall;
   logic               load_use;

   // ---------------------------------------------------------------- forwarding
   always_comb begin
      fwd_a_sel = 2'd0;
      if (id_re1 && mem_rf_we && (mem_wR == id_rR1) && (mem_wR != '0))
         fwd_a_sel = 2'd1;
      else if (id_re1 && wb_rf_we && (wb_wR == id_rR1) && (wb_wR != '0))
         fwd_a_sel = 2'd2;
   end

   always_comb begin
      fwd_b_sel = 2'd0;
      if (id_re2 && mem_rf_we && (mem_wR == id_rR2) && (mem_wR != '0))
         fwd_b_sel = 2'd1;
      else if (id_re2 && wb_rf_we && (wb_wR == id_rR2) && (wb_wR != '0))
         fwd_b_sel = 2'd2;
   end

   // ---------------------------------------------------------- RAM wait FSM
   // The RUN cycle that sees the access already stalls, so WAIT only needs
   // RAM_LAT-2 further stall cycles; its final cnt==0 cycle releases the
   // pipeline and, being in WAIT, cannot re-trigger on the same access.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      memstall = 1'b0;
      unique case (state_q)
         ST_RUN: begin
            if (MULTI && mem_ram_acc) begin
               memstall = 1'b1;
               state_d  = ST_WAIT;
               cnt_d    = CNT_W'(CNT_INIT);
            end
         end
         ST_WAIT: begin
            if (cnt_q != '0) begin
               memstall = 1'b1;
               cnt_d    = cnt_q - 1'b1;
            end else begin
               state_d  = ST_RUN;
            end
         end
         default: begin
            state_d = ST_RUN;
            cnt_d   = '0;
         end
      endcase
      busy_d = (state_d == ST_WAIT) && (cnt_d != '0);
   end

   // ------------------------------------------------------- hazard decisions
   always_comb begin
      load_use = ex_rf_we && (ex_rf_wsel == LOAD_SEL) && (ex_wR != '0) &&
                 ((id_re1 && (ex_wR == id_rR1)) || (id_re2 && (ex_wR == id_rR2)));
   end

   // lu_block_q suppresses a second load-use stall on the cycle after one was
   // issued, so the response is one cycle even if the inputs do not change.
   // A freeze keeps it as is, since nothing moved.
   always_comb begin
      stall_pc     = 1'b0;
      stall_if_id  = 1'b0;
      stall_id_ex  = 1'b0;
      stall_ex_mem = 1'b0;
      flush_if_id  = 1'b0;
      flush_id_ex  = 1'b0;
      flush_mem_wb = 1'b0;
      lu_block_d   = 1'b0;
      if (memstall) begin
         stall_pc     = 1'b1;
         stall_if_id  = 1'b1;
         stall_id_ex  = 1'b1;
         stall_ex_mem = 1'b1;
         flush_mem_wb = 1'b1;
         lu_block_d   = lu_block_q;
      end else if (ex_br_taken) begin
         flush_if_id  = 1'b1;
         flush_id_ex  = 1'b1;
      end else if (load_use && !lu_block_q) begin
         stall_pc     = 1'b1;
         stall_if_id  = 1'b1;
         flush_id_ex  = 1'b1;
         lu_block_d   = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_RUN;
         cnt_q      <= '0;
         busy_q     <= 1'b0;
         lu_block_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         busy_q     <= busy_d;
         lu_block_q <= lu_block_d;
      end
   end

   assign busy = busy_q;

`ifdef HAZARD_PERF_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;
   logic [31:0] flush_cnt_q, flush_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q + {31'd0, stall_pc};
      flush_cnt_d = flush_cnt_q + {31'd0, flush_id_ex};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [4:0] id_rR1, id_rR2, ex_wR, mem_wR, wb_wR;
   logic       id_re1, id_re2, ex_rf_we, ex_br_taken;
   logic [1:0] ex_rf_wsel;
   logic       mem_rf_we, mem_ram_acc, wb_rf_we;
   logic [1:0] fwd_a_sel, fwd_b_sel;
   logic       stall_pc, stall_if_id, stall_id_ex, stall_ex_mem;
   logic       flush_if_id, flush_id_ex, flush_mem_wb, busy;
`ifdef HAZARD_PERF_EN
   logic [31:0] stall_cnt, flush_cnt;
`endif

   int tests  = 0;
   int failed = 0;

   pipe_hazard_ctrl #(.RAM_LAT(3), .LOAD_SEL(2'd1)) dut (
      .clk(clk), .rst_n(rst_n),
      .id_rR1(id_rR1), .id_rR2(id_rR2), .id_re1(id_re1), .id_re2(id_re2),
      .ex_wR(ex_wR), .ex_rf_we(ex_rf_we), .ex_rf_wsel(ex_rf_wsel),
      .ex_br_taken(ex_br_taken),
      .mem_wR(mem_wR), .mem_rf_we(mem_rf_we), .mem_ram_acc(mem_ram_acc),
      .wb_wR(wb_wR), .wb_rf_we(wb_rf_we),
      .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
      .stall_pc(stall_pc), .stall_if_id(stall_if_id),
      .stall_id_ex(stall_id_ex), .stall_ex_mem(stall_ex_mem),
      .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
      .flush_mem_wb(flush_mem_wb), .busy(busy)
`ifdef HAZARD_PERF_EN
      , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
   );

   always #5 clk = ~clk;

   // Output word: {fwd_a[1:0], fwd_b[1:0], stall_pc, stall_if_id, stall_id_ex,
   //               stall_ex_mem, flush_if_id, flush_id_ex, flush_mem_wb}
   localparam logic [6:0] P_NONE = 7'b0000000;
   localparam logic [6:0] P_LU   = 7'b1100010;
   localparam logic [6:0] P_BR   = 7'b0000110;
   localparam logic [6:0] P_MEM  = 7'b1111001;

   typedef struct {
      string      name;
      logic [4:0] rr1, rr2;
      logic       re1, re2;
      logic [4:0] ex_wr;
      logic       ex_we;
      logic [1:0] ex_wsel;
      logic       br;
      logic [4:0] mem_wr;
      logic       mem_we, mem_acc;
      logic [4:0] wb_wr;
      logic       wb_we;
      logic [10:0] exp;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(string n, int rr1, int rr2, int re1, int re2,
                               int exw, int exwe, int exws, int br,
                               int mw, int mwe, int macc, int ww, int wwe,
                               logic [10:0] e);
      vec_t v;
      v.name = n;     v.rr1 = 5'(rr1);   v.rr2 = 5'(rr2);
      v.re1 = 1'(re1); v.re2 = 1'(re2);
      v.ex_wr = 5'(exw); v.ex_we = 1'(exwe); v.ex_wsel = 2'(exws);
      v.br = 1'(br);
      v.mem_wr = 5'(mw); v.mem_we = 1'(mwe); v.mem_acc = 1'(macc);
      v.wb_wr = 5'(ww);  v.wb_we = 1'(wwe);
      v.exp = e;
      return v;
   endfunction

   function automatic logic [10:0] outs();
      return {fwd_a_sel, fwd_b_sel, stall_pc, stall_if_id, stall_id_ex,
              stall_ex_mem, flush_if_id, flush_id_ex, flush_mem_wb};
   endfunction

   task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         failed++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

   task automatic idle();
      id_rR1 = '0; id_rR2 = '0; id_re1 = 0; id_re2 = 0;
      ex_wR = '0; ex_rf_we = 0; ex_rf_wsel = '0; ex_br_taken = 0;
      mem_wR = '0; mem_rf_we = 0; mem_ram_acc = 0;
      wb_wR = '0; wb_rf_we = 0;
   endtask

   task automatic drive(vec_t v);
      id_rR1 = v.rr1; id_rR2 = v.rr2; id_re1 = v.re1; id_re2 = v.re2;
      ex_wR = v.ex_wr; ex_rf_we = v.ex_we; ex_rf_wsel = v.ex_wsel;
      ex_br_taken = v.br;
      mem_wR = v.mem_wr; mem_rf_we = v.mem_we; mem_ram_acc = v.mem_acc;
      wb_wR = v.wb_wr; wb_rf_we = v.wb_we;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 0;
      #1;
      @(negedge clk);
      rst_n = 1;
   endtask

   initial begin
      tbl.push_back(mk("idle",        0,0,0,0, 0,0,0,0, 0,0,0, 0,0, {4'd0, P_NONE}));
      tbl.push_back(mk("fwd_b_mem",   0,3,0,1, 0,0,0,0, 3,1,0, 3,1, {2'd0,2'd1, P_NONE}));
      tbl.push_back(mk("fwd_b_wb",    0,3,0,1, 0,0,0,0, 3,0,0, 3,1, {2'd0,2'd2, P_NONE}));
      tbl.push_back(mk("fwd_b_r0",    0,0,0,1, 0,0,0,0, 0,1,0, 0,1, {4'd0, P_NONE}));
      tbl.push_back(mk("fwd_a_mem",   7,0,1,0, 0,0,0,0, 7,1,0, 0,0, {2'd1,2'd0, P_NONE}));
      tbl.push_back(mk("fwd_a_nore",  7,0,0,0, 0,0,0,0, 7,1,0, 7,1, {4'd0, P_NONE}));
      tbl.push_back(mk("fwd_ab_mix",  9,4,1,1, 0,0,0,0, 4,1,0, 9,1, {2'd2,2'd1, P_NONE}));
      tbl.push_back(mk("lu_rr1",      5,0,1,0, 5,1,1,0, 0,0,0, 0,0, {4'd0, P_LU}));
      tbl.push_back(mk("lu_rr2",      0,6,0,1, 6,1,1,0, 0,0,0, 0,0, {4'd0, P_LU}));
      tbl.push_back(mk("lu_not_load", 5,0,1,0, 5,1,0,0, 0,0,0, 0,0, {4'd0, P_NONE}));
      tbl.push_back(mk("lu_x0",       0,0,1,0, 0,1,1,0, 0,0,0, 0,0, {4'd0, P_NONE}));
      tbl.push_back(mk("lu_no_re",    0,6,0,0, 6,1,1,0, 0,0,0, 0,0, {4'd0, P_NONE}));
      tbl.push_back(mk("lu_no_we",    5,0,1,0, 5,0,1,0, 0,0,0, 0,0, {4'd0, P_NONE}));
      tbl.push_back(mk("branch",      0,0,0,0, 0,0,0,1, 0,0,0, 0,0, {4'd0, P_BR}));
      tbl.push_back(mk("br_over_lu",  5,0,1,0, 5,1,1,1, 0,0,0, 0,0, {4'd0, P_BR}));
      tbl.push_back(mk("mem_over_br", 5,0,1,0, 5,1,1,1, 0,0,1, 0,0, {4'd0, P_MEM}));
      tbl.push_back(mk("fwd_in_mstl", 2,0,1,0, 0,0,0,0, 2,1,1, 0,0, {2'd1,2'd0, P_MEM}));

      // reset state
      idle();
      rst_n = 0;
      #2;
      chk("rst_outs", 32'(outs()), 32'(0));
      chk("rst_busy", 32'(busy), 32'(0));
      @(negedge clk);
      rst_n = 1;

      // table: each vector from a quiescent RUN state
      foreach (tbl[i]) begin
         @(negedge clk);
         drive(tbl[i]);
         #1;
         chk(tbl[i].name, 32'(outs()), 32'(tbl[i].exp));
         @(negedge clk);
         idle();
         repeat (3) @(negedge clk);
      end
      chk("tbl_busy_idle", 32'(busy), 32'(0));

      // load-use held for two cycles: stall only in the first
      @(negedge clk);
      drive(tbl[7]);
      #1;
      chk("lu_seq_c0", 32'(outs()), {21'd0, 4'd0, P_LU});
      @(negedge clk);
      #1;
      chk("lu_seq_c1", 32'(outs()), {21'd0, 4'd0, P_NONE});
      @(negedge clk);
      idle();

      // RAM wait states, RAM_LAT=3: 2 stall cycles, busy for 1
      do_reset();
      @(negedge clk);
      mem_ram_acc = 1;
      #1;
      chk("ram_c0_outs", 32'(outs()), {25'd0, P_MEM});
      chk("ram_c0_busy", 32'(busy), 32'(0));
      @(negedge clk);
      #1;
      chk("ram_c1_outs", 32'(outs()), {25'd0, P_MEM});
      chk("ram_c1_busy", 32'(busy), 32'(1));
      @(negedge clk);
      #1;
      chk("ram_c2_outs", 32'(outs()), {25'd0, P_NONE});
      chk("ram_c2_busy", 32'(busy), 32'(0));
      @(negedge clk);
      mem_ram_acc = 0;
      #1;
      chk("ram_c3_outs", 32'(outs()), {25'd0, P_NONE});
`ifdef HAZARD_PERF_EN
      chk("perf_stall_cnt", stall_cnt, 32'd2);
      chk("perf_flush_cnt", flush_cnt, 32'd0);
`endif

      // branch during WAIT: deferred until memstall drops, then one flush
      @(negedge clk);
      mem_ram_acc = 1;
      ex_br_taken = 1;
      #1;
      chk("brw_c0", 32'(outs()), {25'd0, P_MEM});
      @(negedge clk);
      #1;
      chk("brw_c1", 32'(outs()), {25'd0, P_MEM});
      @(negedge clk);
      #1;
      chk("brw_c2", 32'(outs()), {25'd0, P_BR});
      @(negedge clk);
      mem_ram_acc = 0;
      ex_br_taken = 0;
      #1;
      chk("brw_c3", 32'(outs()), {25'd0, P_NONE});

      // reset asserted mid-WAIT: busy and stalls drop without a clock edge
      @(negedge clk);
      mem_ram_acc = 1;
      @(negedge clk);
      mem_ram_acc = 0;
      #1;
      chk("rstw_pre_outs", 32'(outs()), {25'd0, P_MEM});
      chk("rstw_pre_busy", 32'(busy), 32'(1));
      #1;
      rst_n = 0;
      #1;
      chk("rstw_outs", 32'(outs()), {25'd0, P_NONE});
      chk("rstw_busy", 32'(busy), 32'(0));
`ifdef HAZARD_PERF_EN
      chk("perf_rst_stall", stall_cnt, 32'd0);
      chk("perf_rst_flush", flush_cnt, 32'd0);
`endif
      @(negedge clk);
      rst_n = 1;
      @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish, got running expected done");
      $fatal(1, "timeout");
   end

endmodule
